// File: rtl/result_broadcast_queue.sv
// Completion queue: one holding slot per functional unit, drained round-robin onto a registered CDB.
// Optional mispredict flush input is enabled by defining BQ_FLUSH_EN.
module result_broadcast_queue #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int SRC_WIDTH  = $clog2(NUM_FU)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FU-1:0]            fu_done,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
  output logic [NUM_FU-1:0]            queued,
  input  logic                         cdb_stall,
  output logic                         cdb_valid,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  output logic [SRC_WIDTH-1:0]         cdb_src,
  output logic                         overflow
`ifdef BQ_FLUSH_EN
  ,
  input  logic                         flush
`endif
);

  logic [NUM_FU-1:0]     slot_valid_r;
  logic [DATA_WIDTH-1:0] slot_data_r [NUM_FU];
  logic [TAG_WIDTH-1:0]  slot_tag_r  [NUM_FU];
  logic [SRC_WIDTH-1:0]  rr_ptr_r;
  logic                  overflow_r;
  logic                  cdb_valid_r;
  logic [DATA_WIDTH-1:0] cdb_data_r;
  logic [TAG_WIDTH-1:0]  cdb_tag_r;
  logic [SRC_WIDTH-1:0]  cdb_src_r;

  logic                  adv_s;
  logic                  grant_any_s;
  logic [SRC_WIDTH-1:0]  grant_idx_s;
  logic [SRC_WIDTH-1:0]  scan_idx_s;
  logic [SRC_WIDTH-1:0]  rr_next_s;
  logic [NUM_FU-1:0]     grant_vec_s;
  logic [NUM_FU-1:0]     slot_free_s;
  logic [NUM_FU-1:0]     accept_s;
  logic [NUM_FU-1:0]     refuse_s;
  logic                  block_s;

  // Acceptance is blocked while the queue is being cleared.
`ifdef BQ_FLUSH_EN
  assign block_s = rst | flush;
`else
  assign block_s = rst;
`endif

  // Round-robin arbiter: first valid slot at or after rr_ptr, only when the CDB can advance.
  always_comb begin
    adv_s       = ~cdb_valid_r | ~cdb_stall;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    scan_idx_s  = '0;
    grant_vec_s = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx_s = SRC_WIDTH'((int'(rr_ptr_r) + k) % NUM_FU);
      if (adv_s && !grant_any_s && slot_valid_r[scan_idx_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = scan_idx_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s) begin
      grant_vec_s[grant_idx_s] = 1'b1;
    end else begin
      grant_vec_s = '0;
    end
    if (grant_idx_s == SRC_WIDTH'(NUM_FU - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_idx_s + {{(SRC_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Same-cycle accept/refuse answer; a slot being granted can take a new result at once.
  always_comb begin
    slot_free_s = ~slot_valid_r | grant_vec_s;
    if (block_s) begin
      accept_s = '0;
      refuse_s = '0;
    end else begin
      accept_s = fu_done & slot_free_s;
      refuse_s = fu_done & ~slot_free_s;
    end
  end

  assign queued = accept_s;

  // Holding slots: capture on accept, release on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        slot_data_r[i] <= '0;
        slot_tag_r[i]  <= '0;
      end
    end
`ifdef BQ_FLUSH_EN
    else if (flush) begin
      slot_valid_r <= '0;
    end
`endif
    else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept_s[i]) begin
          slot_valid_r[i] <= 1'b1;
          slot_data_r[i]  <= fu_result[i*DATA_WIDTH +: DATA_WIDTH];
          slot_tag_r[i]   <= fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end else if (grant_vec_s[i]) begin
          slot_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // CDB register, round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      overflow_r  <= 1'b0;
      cdb_valid_r <= 1'b0;
      cdb_data_r  <= '0;
      cdb_tag_r   <= '0;
      cdb_src_r   <= '0;
    end else begin
      overflow_r <= overflow_r | (|refuse_s);
`ifdef BQ_FLUSH_EN
      if (flush) begin
        cdb_valid_r <= 1'b0;
        rr_ptr_r    <= '0;
      end else
`endif
      if (grant_any_s) begin
        cdb_valid_r <= 1'b1;
        cdb_data_r  <= slot_data_r[grant_idx_s];
        cdb_tag_r   <= slot_tag_r[grant_idx_s];
        cdb_src_r   <= grant_idx_s;
        rr_ptr_r    <= rr_next_s;
      end else if (adv_s) begin
        cdb_valid_r <= 1'b0;
      end
    end
  end

  assign cdb_valid = cdb_valid_r;
  assign cdb_data  = cdb_data_r;
  assign cdb_tag   = cdb_tag_r;
  assign cdb_src   = cdb_src_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_result_broadcast_queue.sv
// Directed self-checking bench for result_broadcast_queue (NUM_FU=4, 32-bit data, 7-bit tags).
module tb_result_broadcast_queue;

  logic         clk;
  logic         rst;
  logic [3:0]   fu_done;
  logic [127:0] fu_result;
  logic [27:0]  fu_tag;
  logic [3:0]   queued;
  logic         cdb_stall;
  logic         cdb_valid;
  logic [31:0]  cdb_data;
  logic [6:0]   cdb_tag;
  logic [1:0]   cdb_src;
  logic         overflow;
`ifdef BQ_FLUSH_EN
  logic         flush;
`endif

  int test_cnt = 0;
  int fail_cnt = 0;

  result_broadcast_queue dut (
    .clk       (clk),
    .rst       (rst),
    .fu_done   (fu_done),
    .fu_result (fu_result),
    .fu_tag    (fu_tag),
    .queued    (queued),
    .cdb_stall (cdb_stall),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_src   (cdb_src),
    .overflow  (overflow)
`ifdef BQ_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_fu(input int i, input logic [31:0] d, input logic [6:0] t);
    fu_result[i*32 +: 32] = d;
    fu_tag[i*7 +: 7]      = t;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    fu_done   = 4'b0000;
    cdb_stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_cdb(input string tag, input logic [1:0] src, input logic [31:0] data);
    check_val({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    check_val({tag, "_src"},   64'(cdb_src),   64'(src));
    check_val({tag, "_data"},  64'(cdb_data),  64'(data));
  endtask

  initial begin
    rst       = 1'b1;
    fu_done   = 4'b1111;
    fu_result = '0;
    fu_tag    = '0;
    cdb_stall = 1'b0;
`ifdef BQ_FLUSH_EN
    flush     = 1'b0;
`endif
    tick();
    tick();
    check_val("rst_queued",    64'(queued),    64'd0);
    check_val("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check_val("rst_cdb_data",  64'(cdb_data),  64'd0);
    check_val("rst_cdb_tag",   64'(cdb_tag),   64'd0);
    check_val("rst_cdb_src",   64'(cdb_src),   64'd0);
    check_val("rst_overflow",  64'(overflow),  64'd0);

    // Single completion, two-cycle latency
    rst     = 1'b0;
    fu_done = 4'b0001;
    load_fu(0, 32'hDEADBEEF, 7'h15);
    settle();
    check_val("single_queued", 64'(queued), 64'h1);
    tick();
    fu_done = 4'b0000;
    check_val("single_t1_valid", 64'(cdb_valid), 64'd0);
    tick();
    check_cdb("single_t2", 2'd0, 32'hDEADBEEF);
    check_val("single_t2_tag", 64'(cdb_tag), 64'h15);
    tick();
    check_val("single_drain", 64'(cdb_valid), 64'd0);

    // Four simultaneous completions drain 0,1,2,3
    do_reset();
    fu_done = 4'b1111;
    for (int i = 0; i < 4; i++) load_fu(i, 32'hA0 + 32'(i), 7'h20 + 7'(i));
    settle();
    check_val("four_queued", 64'(queued), 64'hF);
    tick();
    fu_done = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_cdb($sformatf("four_%0d", k), 2'(k), 32'hA0 + 32'(k));
      check_val($sformatf("four_%0d_tag", k), 64'(cdb_tag), 64'h20 + 64'(k));
    end
    tick();
    check_val("four_empty", 64'(cdb_valid), 64'd0);

    // Stall holds src 2 for three cycles, then src 3 follows once
    do_reset();
    fu_done = 4'b1100;
    load_fu(2, 32'hB2, 7'h32);
    load_fu(3, 32'hB3, 7'h33);
    tick();
    fu_done = 4'b0000;
    tick();
    check_cdb("stall_pre", 2'd2, 32'hB2);
    cdb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_cdb($sformatf("stall_hold%0d", k), 2'd2, 32'hB2);
    end
    cdb_stall = 1'b0;
    tick();
    check_cdb("stall_release", 2'd3, 32'hB3);
    tick();
    check_val("stall_nodup", 64'(cdb_valid), 64'd0);

    // Overflow: slot 1 full while CDB stalled
    do_reset();
    fu_done = 4'b0010;
    load_fu(1, 32'hC1, 7'h41);
    tick();
    fu_done = 4'b0000;
    tick();
    check_cdb("ovf_first", 2'd1, 32'hC1);
    cdb_stall = 1'b1;
    fu_done   = 4'b0010;
    load_fu(1, 32'hC5, 7'h45);
    settle();
    check_val("ovf_fill_queued", 64'(queued), 64'h2);
    tick();
    load_fu(1, 32'hC9, 7'h49);
    settle();
    check_val("ovf_refused", 64'(queued), 64'h0);
    tick();
    fu_done = 4'b0000;
    check_val("ovf_set", 64'(overflow), 64'd1);
    tick();
    check_val("ovf_sticky", 64'(overflow), 64'd1);
    check_cdb("ovf_hold", 2'd1, 32'hC1);
    cdb_stall = 1'b0;
    tick();
    check_cdb("ovf_second", 2'd1, 32'hC5);
    rst     = 1'b1;
    fu_done = 4'b0010;
    settle();
    check_val("ovf_rst_queued", 64'(queued), 64'h0);
    tick();
    check_val("ovf_rst_overflow", 64'(overflow), 64'd0);
    check_val("ovf_rst_valid", 64'(cdb_valid), 64'd0);
    rst     = 1'b0;
    fu_done = 4'b0000;

    // Round-robin fairness: FU1/FU3 refire on every grant, FU0 fires once
    do_reset();
    fu_done = 4'b1010;
    load_fu(1, 32'h11, 7'h01);
    load_fu(3, 32'h31, 7'h03);
    tick();
    fu_done = 4'b0011;
    load_fu(0, 32'h0F, 7'h00);
    load_fu(1, 32'h12, 7'h01);
    settle();
    check_val("rr_q1", 64'(queued), 64'h3);
    tick();
    check_cdb("rr_g1", 2'd1, 32'h11);
    fu_done = 4'b1000;
    load_fu(3, 32'h32, 7'h03);
    settle();
    check_val("rr_q2", 64'(queued), 64'h8);
    tick();
    check_cdb("rr_g2", 2'd3, 32'h31);
    fu_done = 4'b0000;
    tick();
    check_cdb("rr_g3", 2'd0, 32'h0F);
    fu_done = 4'b0010;
    load_fu(1, 32'h13, 7'h01);
    settle();
    check_val("rr_q4", 64'(queued), 64'h2);
    tick();
    check_cdb("rr_g4", 2'd1, 32'h12);
    fu_done = 4'b1000;
    load_fu(3, 32'h33, 7'h03);
    settle();
    check_val("rr_q5", 64'(queued), 64'h8);
    tick();
    check_cdb("rr_g5", 2'd3, 32'h32);
    fu_done = 4'b0000;
    tick();
    check_cdb("rr_g6", 2'd1, 32'h13);
    tick();
    check_cdb("rr_g7", 2'd3, 32'h33);
    tick();
    check_val("rr_empty", 64'(cdb_valid), 64'd0);
    check_val("rr_no_overflow", 64'(overflow), 64'd0);

`ifdef BQ_FLUSH_EN
    // Flush discards three pending slots and refuses a same-cycle done
    do_reset();
    fu_done = 4'b0111;
    tick();
    fu_done = 4'b1000;
    flush   = 1'b1;
    settle();
    check_val("flush_queued", 64'(queued), 64'h0);
    tick();
    flush   = 1'b0;
    fu_done = 4'b0000;
    check_val("flush_valid", 64'(cdb_valid), 64'd0);
    tick();
    check_val("flush_empty", 64'(cdb_valid), 64'd0);
    check_val("flush_overflow", 64'(overflow), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
